// File: rtl/riscv_dp_div_ctrl.sv
// Radix-2 restoring divider sequencer for RISC-V DIV/DIVU/REM/REMU that borrows the datapath ALU for its trial subtraction.
// Optional macro RISCV_DIV_KILL_EN adds an ikill input that aborts a running operation.

`ifndef RISCV_ALU_SUB_OP
`define RISCV_ALU_SUB_OP 4'b1000
`endif

module riscv_dp_div_ctrl #(
   parameter int MP_DATA_WIDTH = 32
) (
   input  logic                     iclk,
   input  logic                     irst,
   input  logic                     istart,
`ifdef RISCV_DIV_KILL_EN
   input  logic                     ikill,
`endif
   input  logic [1:0]               iop,
   input  logic [MP_DATA_WIDTH-1:0] idividend,
   input  logic [MP_DATA_WIDTH-1:0] idivisor,
   output logic                     obusy,
   output logic                     odone,
   output logic [MP_DATA_WIDTH-1:0] oresult,
   output logic [3:0]               oalu_ctrl,
   output logic [MP_DATA_WIDTH-1:0] oalu_src_a,
   output logic [MP_DATA_WIDTH-1:0] oalu_src_b,
   input  logic [MP_DATA_WIDTH-1:0] ialu_result,
   input  logic                     ialu_carry
);

   localparam int W  = MP_DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [1:0]     op;
   logic [W-1:0]   opa, opb;
   logic [W-1:0]   div_mag;
   logic [W-1:0]   rem_r, quo_r;
   logic [CW-1:0]  cnt;
   logic           q_neg, r_neg;
   logic           kill;
   logic           is_signed;
   logic [W-1:0]   mag_a, mag_b;
   logic [W-1:0]   sel_val, fix_val;
   logic           neg_sel;

`ifdef RISCV_DIV_KILL_EN
   assign kill = ikill && (state != S_IDLE);
`else
   assign kill = 1'b0;
`endif

   // iop[0] = 0 marks the signed variants (DIV, REM)
   assign is_signed = ~op[0];
   assign mag_a     = (is_signed && opa[W-1]) ? (~opa + W'(1)) : opa;
   assign mag_b     = (is_signed && opb[W-1]) ? (~opb + W'(1)) : opb;

   assign sel_val = op[1] ? rem_r : quo_r;
   assign neg_sel = is_signed && (op[1] ? r_neg : q_neg);
   assign fix_val = neg_sel ? (~sel_val + W'(1)) : sel_val;

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (istart) state_nxt = S_PREP;
         S_PREP: state_nxt = (opb == '0) ? S_DONE : S_ITER;
         S_ITER: if (cnt == '0) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (kill) state_nxt = S_IDLE;
   end

   assign obusy      = (state != S_IDLE);
   assign odone      = (state == S_DONE) && !kill;
   assign oalu_ctrl  = `RISCV_ALU_SUB_OP;
   assign oalu_src_a = (state == S_ITER) ? {rem_r[W-2:0], quo_r[W-1]} : '0;
   assign oalu_src_b = (state == S_ITER) ? div_mag : '0;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         op      <= '0;
         opa     <= '0;
         opb     <= '0;
         div_mag <= '0;
         rem_r   <= '0;
         quo_r   <= '0;
         cnt     <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         oresult <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (istart) begin
                  op  <= iop;
                  opa <= idividend;
                  opb <= idivisor;
               end
            end
            S_PREP: begin
               div_mag <= mag_b;
               quo_r   <= mag_a;
               rem_r   <= '0;
               cnt     <= CW'(W - 1);
               q_neg   <= opa[W-1] ^ opb[W-1];
               r_neg   <= opa[W-1];
               // Divide by zero skips iteration: all-ones quotient, dividend as remainder
               if (opb == '0 && !kill) oresult <= op[1] ? opa : '1;
            end
            S_ITER: begin
               if (ialu_carry) begin
                  rem_r <= ialu_result;
                  quo_r <= {quo_r[W-2:0], 1'b1};
               end else begin
                  rem_r <= {rem_r[W-2:0], quo_r[W-1]};
                  quo_r <= {quo_r[W-2:0], 1'b0};
               end
               cnt <= cnt - CW'(1);
            end
            S_FIX: begin
               if (!kill) oresult <= fix_val;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_dp_div_ctrl.sv
// Self-checking bench for riscv_dp_div_ctrl: models the datapath ALU and scoreboards results against a reference divider.
// Exercises the kill path when RISCV_DIV_KILL_EN is defined.

`ifndef RISCV_ALU_SUB_OP
`define RISCV_ALU_SUB_OP 4'b1000
`endif

module tb_riscv_dp_div_ctrl;

   localparam int W = 32;

   logic          iclk = 1'b0;
   logic          irst;
   logic          istart;
   logic [1:0]    iop;
   logic [W-1:0]  idividend, idivisor;
   logic          obusy, odone;
   logic [W-1:0]  oresult;
   logic [3:0]    oalu_ctrl;
   logic [W-1:0]  oalu_src_a, oalu_src_b;
   logic [W-1:0]  ialu_result;
   logic          ialu_carry;
`ifdef RISCV_DIV_KILL_EN
   logic          ikill;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] res_q[$];
   int           lat_q[$];

   always #5 iclk = ~iclk;

   // Datapath ALU stand-in: subtract, carry means no borrow
   assign ialu_result = oalu_src_a - oalu_src_b;
   assign ialu_carry  = (oalu_src_a >= oalu_src_b);

   riscv_dp_div_ctrl #(.MP_DATA_WIDTH(W)) dut (
      .iclk        (iclk),
      .irst        (irst),
      .istart      (istart),
`ifdef RISCV_DIV_KILL_EN
      .ikill       (ikill),
`endif
      .iop         (iop),
      .idividend   (idividend),
      .idivisor    (idivisor),
      .obusy       (obusy),
      .odone       (odone),
      .oresult     (oresult),
      .oalu_ctrl   (oalu_ctrl),
      .oalu_src_a  (oalu_src_a),
      .oalu_src_b  (oalu_src_b),
      .ialu_result (ialu_result),
      .ialu_carry  (ialu_carry)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] r;
      if (b == '0) begin
         r = op[1] ? a : '1;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = op[1] ? '0 : a;
      end else begin
         unique case (op)
            2'b00: r = 32'($signed(a) / $signed(b));
            2'b01: r = a / b;
            2'b10: r = 32'($signed(a) % $signed(b));
            default: r = a % b;
         endcase
      end
      return r;
   endfunction

   function automatic logic [W-1:0] ref_mag(input logic [1:0] op, input logic [W-1:0] b);
      return (!op[0] && b[W-1]) ? (0 - b) : b;
   endfunction

   // Starts in an IDLE cycle at a negedge; returns at a negedge with the DUT idle again.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int poke_at);
      int n;
      logic [W-1:0] exp_res;
      int exp_lat;
      check({tag, " idle before start"}, 64'(obusy), 64'd0);
      istart = 1'b1; iop = op; idividend = a; idivisor = b;
      res_q.push_back(ref_op(op, a, b));
      lat_q.push_back((b == '0) ? 2 : W + 3);
      @(posedge iclk);
      @(negedge iclk);
      istart = 1'b0;
      n = 1;
      while (odone !== 1'b1 && n < 64) begin
         if (n == 1) begin
            check({tag, " busy in PREP"}, 64'(obusy), 64'd1);
            check({tag, " src_a zero outside ITER"}, 64'(oalu_src_a), 64'd0);
         end
         if (n == 2 && b != '0) begin
            check({tag, " src_b divisor magnitude"}, 64'(oalu_src_b), 64'(ref_mag(op, b)));
            check({tag, " alu ctrl"}, 64'(oalu_ctrl), 64'(`RISCV_ALU_SUB_OP));
         end
         if (n == poke_at) begin
            istart = 1'b1; iop = ~op; idividend = ~a; idivisor = b + 32'd3;
         end else begin
            istart = 1'b0;
         end
         @(negedge iclk);
         n++;
      end
      istart = 1'b0;
      exp_res = res_q.pop_front();
      exp_lat = lat_q.pop_front();
      check({tag, " done latency"}, 64'(n), 64'(exp_lat));
      check({tag, " result"}, 64'(oresult), 64'(exp_res));
      @(negedge iclk);
      check({tag, " done is one cycle"}, 64'(odone), 64'd0);
      check({tag, " result held"}, 64'(oresult), 64'(exp_res));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] prev;
      logic saw_done;
      irst = 1'b1; istart = 1'b0; iop = '0; idividend = '0; idivisor = '0;
`ifdef RISCV_DIV_KILL_EN
      ikill = 1'b0;
`endif
      repeat (3) @(negedge iclk);
      check("reset obusy", 64'(obusy), 64'd0);
      check("reset odone", 64'(odone), 64'd0);
      check("reset oresult", 64'(oresult), 64'd0);
      check("reset src_a", 64'(oalu_src_a), 64'd0);
      check("reset src_b", 64'(oalu_src_b), 64'd0);
      irst = 1'b0;
      @(negedge iclk);

      run_op("divu 100/7",   2'b01, 32'd100, 32'd7, 0);
      run_op("remu 100/7",   2'b11, 32'd100, 32'd7, 0);
      run_op("div -100/7",   2'b00, 32'hFFFF_FF9C, 32'd7, 0);
      run_op("rem -100/7",   2'b10, 32'hFFFF_FF9C, 32'd7, 0);
      run_op("div overflow", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("divu 55/0",    2'b01, 32'd55, 32'd0, 0);
      run_op("rem 55/0",     2'b10, 32'd55, 32'd0, 0);
      run_op("div 1000/-3 busy poke", 2'b00, 32'd1000, 32'hFFFF_FFFD, 5);
      run_op("rem 7/-3",     2'b10, 32'd7, 32'hFFFF_FFFD, 0);
      run_op("divu big",     2'b01, 32'hFFFF_0000, 32'h0000_1234, 0);

`ifdef RISCV_DIV_KILL_EN
      prev = oresult;
      istart = 1'b1; iop = 2'b01; idividend = 32'd1000; idivisor = 32'd10;
      @(posedge iclk);
      @(negedge iclk);
      istart = 1'b0;
      for (int n = 1; n < 20; n++) @(negedge iclk);
      ikill = 1'b1;
      @(negedge iclk);
      ikill = 1'b0;
      check("kill obusy", 64'(obusy), 64'd0);
      check("kill keeps result", 64'(oresult), 64'(prev));
      saw_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge iclk);
         if (odone === 1'b1) saw_done = 1'b1;
      end
      check("kill suppresses done", 64'(saw_done), 64'd0);
      check("kill result still held", 64'(oresult), 64'(prev));
`endif

      check("result nonzero before reset", 64'(oresult == '0), 64'd0);
      istart = 1'b1; iop = 2'b01; idividend = 32'd5000; idivisor = 32'd9;
      @(posedge iclk);
      @(negedge iclk);
      istart = 1'b0;
      for (int n = 1; n < 10; n++) @(negedge iclk);
      irst = 1'b1;
      #1;
      check("mid-op reset obusy", 64'(obusy), 64'd0);
      check("mid-op reset oresult", 64'(oresult), 64'd0);
      check("mid-op reset src_b", 64'(oalu_src_b), 64'd0);
      saw_done = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge iclk);
         if (odone === 1'b1) saw_done = 1'b1;
      end
      irst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge iclk);
         if (odone === 1'b1) saw_done = 1'b1;
      end
      check("mid-op reset no done", 64'(saw_done), 64'd0);

      run_op("divu after reset", 2'b01, 32'd5000, 32'd9, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_dp_div_ctrl.md
# riscv_dp_div_ctrl

Multi-cycle sequencer that runs RISC-V M-extension division (DIV, DIVU, REM, REMU) as a radix-2 restoring divider. It reuses the datapath ALU for its trial subtraction instead of instantiating its own subtractor. It sits beside `riscv_dp_alu` in the datapath: it drives the ALU operand and control inputs during iteration and consumes the ALU result and carry flag. It talks to the pipeline through a start/busy/done handshake.

## Interface
- `MP_DATA_WIDTH`, 32: operand and result width, W; must be a power of two, ≥ 8.
- `iclk` input 1: clock, rising edge.
- `irst` input 1: asynchronous, active-high reset.
- `istart` input 1: request; sampled only in IDLE.
- `iop` input 2: operation, 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `idividend` input W: operand A, captured with `istart`.
- `idivisor` input W: operand B, captured with `istart`.
- `obusy` output 1: high in every state except IDLE.
- `odone` output 1: one-cycle pulse; `oresult` is valid.
- `oresult` output W: quotient or remainder, held until the next accepted `istart`.
- `oalu_ctrl` output 4: ALU control; constant `` `RISCV_ALU_SUB_OP ``.
- `oalu_src_a` output W: ALU operand A, the shifted partial remainder.
- `oalu_src_b` output W: ALU operand B, the divisor magnitude.
- `ialu_result` input W: ALU result, a combinational return.
- `ialu_carry` input 1: ALU carry; 1 means src_a ≥ src_b unsigned.

## Operation
- State machine: IDLE → PREP → ITER → FIX → DONE → IDLE.
- **IDLE**
  - `istart` = 1 latches `iop` and both operands, then moves to PREP.
- **PREP**
  - Signed ops (iop[0] = 0): store the magnitudes |A| and |B|. Compute the negation locally as ~x + 1 (not through the ALU).
  - Record the quotient sign as A[W-1] ^ B[W-1] and the remainder sign as A[W-1]; both apply to signed ops only.
  - Clear the remainder register R. Load the quotient register Q with |A|. Load the iteration counter with W-1.
  - If B = 0, go directly to DONE:
    - DIV/DIVU return all-ones.
    - REM/REMU return the original dividend.
  - Otherwise go to ITER.
- **ITER** (exactly W cycles)
  - Drive `oalu_src_a` = {R[W-2:0], Q[W-1]} and `oalu_src_b` = |B|.
  - On the clock edge, if `ialu_carry`:
    - R ← `ialu_result`
    - Q ← {Q[W-2:0], 1}
  - Otherwise:
    - R ← {R[W-2:0], Q[W-1]}
    - Q ← {Q[W-2:0], 0}
  - The counter decrements each cycle. ITER exits to FIX after the cycle in which the counter is 0.
- **FIX**
  - Select Q for DIV/DIVU and R for REM/REMU.
  - For signed ops, negate Q if the quotient sign is set and negate R if the remainder sign is set.
  - Register the selected value into `oresult`.
- **DONE**
  - `odone` = 1 for one cycle, then the block returns to IDLE.
- Signed overflow (A = 0x8000_0000, B = 0xFFFF_FFFF at W = 32) must produce DIV = 0x8000_0000 and REM = 0 with no special path.
- Outside ITER, `oalu_src_a` and `oalu_src_b` are driven to 0.
- `istart` outside IDLE is ignored; there is no queuing.

## Timing
- Reset values: state IDLE, `obusy` 0, `odone` 0, `oresult` 0, `oalu_src_a` 0, `oalu_src_b` 0, all internal registers 0.
- Let `istart` be sampled at edge k:
  - `obusy` rises after edge k.
  - PREP occupies cycle k+1.
  - ITER occupies cycles k+2 … k+W+1.
  - FIX occupies cycle k+W+2.
  - `odone` is high in cycle k+W+3.
  - Total latency is W+3 cycles (35 at W = 32).
- Divide by zero: `odone` is high in cycle k+2.
- `obusy` falls on the same edge that ends `odone`. A new `istart` is accepted in the very next cycle.
- Reset asserted mid-operation aborts immediately to the reset values; no `odone` is generated.
- The ALU path is combinational within each ITER cycle; there is no extra pipeline stage.

## Configuration
- Macro: `RISCV_DIV_KILL_EN`.
- **Defined:** adds input `ikill` (1 bit).
  - `ikill` = 1 in any state except IDLE forces IDLE on the next edge.
  - `odone` is suppressed and `oresult` keeps its previous value.
  - `ikill` has priority over `istart` and over the DONE transition.
- **Undefined:** no `ikill` port; an operation always runs to completion.

## Test plan
- DIVU 100 / 7 → `odone` in cycle k+35, `oresult` = 14. Repeat as REMU → 2.
- DIV −100 / 7 → 0xFFFF_FFF2 (−14). REM −100 / 7 → 0xFFFF_FFFE (−2).
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. REM of the same operands → 0.
- DIVU 55 / 0 → 0xFFFF_FFFF with `odone` in cycle k+2. REM 55 / 0 → 55.
- Assert `irst` at cycle k+10 of a division → `obusy` 0 and `oresult` 0 immediately, no `odone` pulse. A second `istart` that arrives while busy is ignored.
- With `RISCV_DIV_KILL_EN`: `ikill` in cycle k+20 → IDLE at the next edge, no `odone`, and `oresult` keeps the prior result.
